// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/acknowledge port between the MEM-stage access controller and memory.
interface mem_access_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues one req/ack access per load/store,
// stalls the front pipeline while it waits and gates regWrite into MEM/WB.
//
// state | meaning
// IDLE  | no access outstanding; a load/store in MEM stalls combinationally and launches
// BUSY  | request outstanding, waiting for ack or timeout
// DONE  | access finished; pipeline advances and MEM/WB captures the result
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] LOAD_ZERO = 32'h0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      memRead_MEM_i,
    input  logic                      memWrite_MEM_i,
    input  logic                      regWrite_MEM_i,
    input  logic [31:0]               addr_MEM_i,
    input  logic [31:0]               wdata_MEM_i,
    mem_access_ctrl_if.master         dmem,
    output logic                      stall_o,
    output logic                      regWrite_gated_o,
    output logic [31:0]               loadOut_MEM_o,
    output logic                      err_o,
    output logic [31:0]               waitCount_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          req_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   load_q;
    logic          err_q;
    logic [31:0]   wait_q;

    logic access;
    logic stall;

    assign access = memRead_MEM_i | memWrite_MEM_i;
    assign stall  = (state_q == S_BUSY) | ((state_q == S_IDLE) & access);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            load_q  <= '0;
            err_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            if (stall) begin
                wait_q <= wait_q + 32'd1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (access) begin
                        addr_q  <= addr_MEM_i;
                        wdata_q <= wdata_MEM_i;
                        we_q    <= memWrite_MEM_i;
                        req_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // ack takes priority over a timeout in the same cycle
                    if (dmem.ack) begin
                        if (!we_q) begin
                            load_q <= dmem.rdata;
                        end
                        req_q   <= 1'b0;
                        state_q <= S_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        load_q  <= LOAD_ZERO;
                        err_q   <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dmem.req         = req_q;
    assign dmem.we          = we_q;
    assign dmem.addr        = addr_q;
    assign dmem.wdata       = wdata_q;
    assign stall_o          = stall;
    assign regWrite_gated_o = regWrite_MEM_i & ~stall;
    assign loadOut_MEM_o    = load_q;
    assign err_o            = err_q;
    assign waitCount_o      = wait_q;

endmodule
